// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: branch redirects, load-use
// interlock and sequencing of the multi-cycle HI/LO multiply/divide unit.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_md_op,
  input  logic        id_md_is_div,
  input  logic        id_reads_hilo,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_rt,
  input  logic        ex_redirect,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        flush_if,
  output logic        flush_id,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stall_q, stall_d;
  logic        load_use;
  logic        md_hold;

  always_comb begin
    load_use = ex_mem_to_reg && (ex_rt != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    md_hold  = (state_q == BUSY) && (id_md_op || id_reads_hilo);

    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    md_start    = 1'b0;

    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush_if    = 1'b1;
      flush_id    = 1'b1;
    end else if (ex_redirect) begin
      // Wrong-path md op in ID is squashed; an operation already running keeps going.
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (md_hold || load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush_id    = 1'b1;
    end else begin
      md_start = id_md_op && (state_q == IDLE);
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = id_md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    stall_d = stall_q;
    if (!pc_write && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign md_busy      = (state_q == BUSY);
  assign md_done      = (state_q == BUSY) && (cnt_q == 6'd0);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected output vectors
// are queued as stimulus is applied and popped when the cycle's outputs settle.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rs = 0, id_uses_rt = 0, id_md_op = 0, id_md_is_div = 0;
  logic        id_reads_hilo = 0, ex_mem_to_reg = 0, ex_redirect = 0;
  logic        pc_write, if_id_write, flush_if, flush_id, md_start, md_busy, md_done;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0]  sb[$];
  logic [6:0]  exp_v;
  logic [31:0] stall_ref;
  wire  [6:0]  obs = {pc_write, if_id_write, flush_if, flush_id, md_start, md_busy, md_done};

  // Expected vectors: {pc_write, if_id_write, flush_if, flush_id, md_start, md_busy, md_done}
  localparam logic [6:0] E_RST      = 7'b0011000;
  localparam logic [6:0] E_RST_BUSY = 7'b0011010;
  localparam logic [6:0] E_NORM     = 7'b1100000;
  localparam logic [6:0] E_START    = 7'b1100100;
  localparam logic [6:0] E_LU       = 7'b0001000;
  localparam logic [6:0] E_REDIR    = 7'b1111000;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_md_op(id_md_op),
    .id_md_is_div(id_md_is_div), .id_reads_hilo(id_reads_hilo),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .pc_write(pc_write), .if_id_write(if_id_write), .flush_if(flush_if),
    .flush_id(flush_id), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .stall_cycles(stall_cycles)
  );

  // Drive one cycle of inputs just after the edge and queue the expected outputs.
  task automatic apply(input logic r, input logic redir, input logic mdop,
                       input logic isdiv, input logic hilo, input logic [6:0] e);
    @(posedge clk); #1;
    rst = r; ex_redirect = redir; id_md_op = mdop; id_md_is_div = isdiv;
    id_reads_hilo = hilo; ex_mem_to_reg = 0; ex_rt = 0;
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    sb.push_back(e);
  endtask

  task automatic apply_load(input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic [6:0] e);
    @(posedge clk); #1;
    rst = 0; ex_redirect = 0; id_md_op = 0; id_md_is_div = 0; id_reads_hilo = 0;
    ex_mem_to_reg = 1; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 1, 0, 0, E_RST);
      @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, exp_v); end
    end
    apply(0, 0, 0, 0, 0, E_NORM);
    @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_release: got %b want %b", obs, exp_v); end
    n_cmp++;
    if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    logic [4:0]  ert[5] = '{8, 0, 8, 9, 8};
    logic [4:0]  rs[5]  = '{8, 0, 8, 3, 1};
    logic [4:0]  rt[5]  = '{0, 0, 0, 9, 8};
    logic        urs[5] = '{1, 1, 0, 0, 0};
    logic        urt[5] = '{0, 0, 0, 1, 0};
    logic [6:0]  e[5]   = '{E_LU, E_NORM, E_NORM, E_LU, E_NORM};
    logic [31:0] d[5]   = '{1, 0, 0, 1, 0};
    for (int k = 0; k < 5; k++) begin
      stall_ref = stall_cycles;
      apply_load(ert[k], rs[k], rt[k], urs[k], urt[k], e[k]);
      @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL load_use case%0d: got %b want %b", k, obs, exp_v); end
      apply(0, 0, 0, 0, 0, E_NORM);
      @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL load_use_after case%0d: got %b want %b", k, obs, exp_v); end
      n_cmp++;
      if (stall_cycles !== stall_ref + d[k]) begin
        n_err++; $display("FAIL load_use_count case%0d: got %0d want %0d", k, stall_cycles, stall_ref + d[k]);
      end
    end
  endtask

  task automatic test_div_mflo();
    stall_ref = stall_cycles;
    apply(0, 0, 1, 1, 0, E_START);
    @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL div_start: got %b want %b", obs, exp_v); end
    for (int i = 1; i <= 33; i++) begin
      apply(0, 0, 0, 0, 1, (i == 33) ? E_NORM : {6'b000101, (i == 32)});
      @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL div_mflo cyc%0d: got %b want %b", i, obs, exp_v); end
    end
    n_cmp++;
    if (stall_cycles !== stall_ref + 32) begin
      n_err++; $display("FAIL div_stall_count: got %0d want %0d", stall_cycles, stall_ref + 32);
    end
  endtask

  task automatic test_redirect_idle();
    apply(0, 1, 1, 0, 0, E_REDIR);
    @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL redirect_idle: got %b want %b", obs, exp_v); end
    apply(0, 0, 0, 0, 0, E_NORM);
    @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL redirect_idle_after: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_redirect_busy();
    apply(0, 0, 1, 0, 0, E_START);
    @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rbusy_start: got %b want %b", obs, exp_v); end
    for (int i = 1; i <= 5; i++) begin
      if (i == 2)      apply(0, 1, 0, 0, 0, 7'b1111010);
      else if (i == 5) apply(0, 0, 0, 0, 0, E_NORM);
      else             apply(0, 0, 0, 0, 0, {6'b110001, (i == 4)});
      @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rbusy cyc%0d: got %b want %b", i, obs, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    apply(0, 0, 1, 0, 0, E_START);
    @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL b2b_start1: got %b want %b", obs, exp_v); end
    for (int i = 1; i <= 10; i++) begin
      if (i <= 4)       apply(0, 0, 1, 0, 0, {6'b000101, (i == 4)});
      else if (i == 5)  apply(0, 0, 1, 0, 0, E_START);
      else if (i <= 9)  apply(0, 0, 0, 0, 0, {6'b110001, (i == 9)});
      else              apply(0, 0, 0, 0, 0, E_NORM);
      @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid_op();
    apply(0, 0, 1, 0, 0, E_START);
    @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rmid_start: got %b want %b", obs, exp_v); end
    for (int i = 1; i <= 7; i++) begin
      if (i == 1)      apply(0, 0, 0, 0, 0, 7'b1100010);
      else if (i == 2) apply(1, 0, 0, 0, 0, E_RST_BUSY);
      else             apply(0, 0, 0, 0, 0, E_NORM);
      @(negedge clk); exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rmid cyc%0d: got %b want %b", i, obs, exp_v); end
    end
    n_cmp++;
    if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL rmid_stall: got %0d want 0", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_div_mflo();
    test_redirect_idle();
    test_redirect_busy();
    test_back_to_back();
    test_reset_mid_op();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
